mig_port_arbiter: RTL

Shares one MIG Native Interface between `NUM_CLIENTS` FIFO-style controllers, each owning its own memory region. It grants the command and write-data paths to one client at a time, for a whole burst. Read data returns in command order, so the block records the issuing client of every accepted read command in a tag FIFO and routes each returning beat to that client. It sits between the client controllers and the MIG user interface.

---
 rtl/mig_arb_pkg.sv | 20 ++
 rtl/mig_arb_tag_fifo.sv | 49 ++++
 rtl/mig_port_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mig_arb_pkg.sv
// Shared types for the MIG port arbiter: FSM state encoding and client-id width.
// Client ids are sized for the largest supported client count so one type serves every build.
package mig_arb_pkg;

    localparam int MAX_CLIENTS = 4;
    localparam int CLIENT_ID_W = $clog2(MAX_CLIENTS);

    typedef logic [CLIENT_ID_W-1:0] client_id_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_BUSY,
        ST_GAP
    } arb_state_t;

    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;

endpackage

// File: rtl/mig_arb_tag_fifo.sv
// Synchronous FIFO of client ids recording the issuer of each outstanding read command.
// Head is visible combinationally; push is dropped when full, pop is dropped when empty.
module mig_arb_tag_fifo
    import mig_arb_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       push_i,
    input  client_id_t data_i,
    input  logic       pop_i,
    output client_id_t data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    client_id_t  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        do_push;
    logic        do_pop;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/mig_port_arbiter.sv
// Shares one MIG native port among clients, one whole burst at a time; grant is 1 cycle after request, data paths are combinational.
// Read commands stall while the read tag FIFO is full; MIG_ARB_FIXED_PRIO_EN selects strict lowest-index priority instead of round-robin.
module mig_port_arbiter
    import mig_arb_pkg::*;
#(
    parameter int NUM_CLIENTS        = 2,
    parameter int MIG_Data_Port_Size = 128,
    parameter int MIG_Addr_Port_Size = 28,
    parameter int RD_TAG_DEPTH       = 64,
    parameter int GAP_CYCLES         = 4
) (
    input  logic                                       aclk,
    input  logic                                       aresetn,
    input  logic                                       init_calib,
    input  logic [NUM_CLIENTS-1:0]                     c_req,
    output logic [NUM_CLIENTS-1:0]                     c_gnt,
    input  logic [NUM_CLIENTS-1:0]                     c_release,
    input  logic [NUM_CLIENTS*MIG_Addr_Port_Size-1:0]  c_app_addr,
    input  logic [NUM_CLIENTS*3-1:0]                   c_app_cmd,
    input  logic [NUM_CLIENTS-1:0]                     c_app_en,
    output logic [NUM_CLIENTS-1:0]                     c_app_rdy,
    input  logic [NUM_CLIENTS*MIG_Data_Port_Size-1:0]  c_app_wdf_data,
    input  logic [NUM_CLIENTS-1:0]                     c_app_wdf_wren,
    input  logic [NUM_CLIENTS-1:0]                     c_app_wdf_end,
    output logic [NUM_CLIENTS-1:0]                     c_app_wdf_rdy,
    output logic [MIG_Data_Port_Size-1:0]              c_rd_data,
    output logic [NUM_CLIENTS-1:0]                     c_rd_data_valid,
    output logic [NUM_CLIENTS-1:0]                     c_rd_data_end,
    output logic [MIG_Addr_Port_Size-1:0]              app_addr,
    output logic [2:0]                                 app_cmd,
    output logic                                       app_en,
    input  logic                                       app_rdy,
    output logic [MIG_Data_Port_Size-1:0]              app_wdf_data,
    output logic                                       app_wdf_wren,
    output logic                                       app_wdf_end,
    input  logic                                       app_wdf_rdy,
    input  logic [MIG_Data_Port_Size-1:0]              app_rd_data,
    input  logic                                       app_rd_data_valid,
    input  logic                                       app_rd_data_end,
    output logic                                       rd_tag_err
);

    localparam int A = MIG_Addr_Port_Size;
    localparam int D = MIG_Data_Port_Size;
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    arb_state_t             state_q;
    client_id_t             gnt_id_q;
    client_id_t             last_gnt_q;
    logic [7:0]             gap_cnt_q;
    logic [NUM_CLIENTS-1:0] c_gnt_q;
    logic                   rd_tag_err_q;

    logic                   win_vld;
    client_id_t             win_id;
    logic [NUM_CLIENTS-1:0] win_oh;

    logic                   busy;
    logic                   sel_en;
    logic [2:0]             sel_cmd;
    logic [A-1:0]           sel_addr;
    logic [D-1:0]           sel_wdata;
    logic                   sel_wren;
    logic                   sel_wend;
    logic                   sel_rel;
    logic                   blk_rd;

    logic                   tag_push;
    logic                   tag_pop;
    client_id_t             tag_head;
    logic                   tag_full;
    logic                   tag_empty;

    assign busy = (state_q == ST_BUSY);

    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
`ifdef MIG_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!win_vld && c_req[i]) begin
                win_vld = 1'b1;
                win_id  = client_id_t'(i);
            end
        end
`else
        // Visit clients in order last_gnt+1, last_gnt+2, ... and take the first requester.
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (!win_vld && c_req[i] &&
                    (((int'(last_gnt_q) + 1 + k) % NUM_CLIENTS) == i)) begin
                    win_vld = 1'b1;
                    win_id  = client_id_t'(i);
                end
            end
        end
`endif
        win_oh = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            win_oh[i] = (win_id == client_id_t'(i));
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_INIT;
            gnt_id_q     <= '0;
            last_gnt_q   <= client_id_t'(NUM_CLIENTS - 1);
            gap_cnt_q    <= '0;
            c_gnt_q      <= '0;
            rd_tag_err_q <= 1'b0;
        end else begin
            if (app_rd_data_valid && tag_empty) rd_tag_err_q <= 1'b1;
            unique case (state_q)
                ST_INIT: begin
                    if (init_calib) state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (win_vld) begin
                        state_q    <= ST_BUSY;
                        gnt_id_q   <= win_id;
                        last_gnt_q <= win_id;
                        c_gnt_q    <= win_oh;
                    end
                end
                ST_BUSY: begin
                    if (sel_rel) begin
                        c_gnt_q   <= '0;
                        gap_cnt_q <= '0;
                        state_q   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) state_q <= ST_IDLE;
                    else                       gap_cnt_q <= gap_cnt_q + 8'd1;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign c_gnt      = c_gnt_q;
    assign rd_tag_err = rd_tag_err_q;

    always_comb begin
        sel_en        = 1'b0;
        sel_cmd       = CMD_READ;
        sel_addr      = '0;
        sel_wdata     = '0;
        sel_wren      = 1'b0;
        sel_wend      = 1'b0;
        sel_rel       = 1'b0;
        c_app_rdy     = '0;
        c_app_wdf_rdy = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (busy && (gnt_id_q == client_id_t'(i))) begin
                sel_en    = c_app_en[i];
                sel_cmd   = c_app_cmd[i*3 +: 3];
                sel_addr  = c_app_addr[i*A +: A];
                sel_wdata = c_app_wdf_data[i*D +: D];
                sel_wren  = c_app_wdf_wren[i];
                sel_wend  = c_app_wdf_end[i];
                sel_rel   = c_release[i];
            end
        end
        // Only reads consume a tag slot, so writes keep flowing when the FIFO is full.
        blk_rd = busy && tag_full && (sel_cmd == CMD_READ);
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (busy && (gnt_id_q == client_id_t'(i))) begin
                c_app_rdy[i]     = app_rdy & ~blk_rd;
                c_app_wdf_rdy[i] = app_wdf_rdy;
            end
        end
    end

    assign app_en       = busy & sel_en & ~blk_rd;
    assign app_cmd      = busy ? sel_cmd : CMD_READ;
    assign app_addr     = busy ? sel_addr : '0;
    assign app_wdf_data = busy ? sel_wdata : '0;
    assign app_wdf_wren = busy & sel_wren;
    assign app_wdf_end  = busy & sel_wend;

    assign tag_push = app_en & app_rdy & (app_cmd == CMD_READ);
    assign tag_pop  = app_rd_data_valid & app_rd_data_end & ~tag_empty;

    mig_arb_tag_fifo #(
        .DEPTH (RD_TAG_DEPTH)
    ) u_tag_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push_i  (tag_push),
        .data_i  (gnt_id_q),
        .pop_i   (tag_pop),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    // Read beats follow the tag at the FIFO head, independent of who holds the grant now.
    assign c_rd_data = app_rd_data;

    always_comb begin
        c_rd_data_valid = '0;
        c_rd_data_end   = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!tag_empty && (tag_head == client_id_t'(i))) begin
                c_rd_data_valid[i] = app_rd_data_valid;
                c_rd_data_end[i]   = app_rd_data_valid & app_rd_data_end;
            end
        end
    end

endmodule
